// File: rtl/alu_4b_pkg.sv
// Shared definitions for the two-requester 4-bit ALU arbiter: opcodes and FSM encoding.
package alu_4b_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_4b_and4.sv
// Bitwise AND gate used as the AND path of the shared datapath.
module alu_4b_and4 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = a & b;

endmodule

// File: rtl/alu_4b_core.sv
// Purely combinational ALU datapath: AND / OR / XOR / unsigned ADD with carry-out.
module alu_4b_core
    import alu_4b_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             carry
);

    logic [WIDTH-1:0] and_s;
    logic [WIDTH:0]   sum_s;

    alu_4b_and4 #(.WIDTH(WIDTH)) u_and (
        .a (a),
        .b (b),
        .y (and_s)
    );

    assign sum_s = {1'b0, a} + {1'b0, b};

    // Select the result for the requested opcode; carry is only meaningful for ADD.
    always_comb begin
        out   = {WIDTH{1'b0}};
        carry = 1'b0;
        case (op)
            OP_AND: out = and_s;
            OP_OR:  out = a | b;
            OP_XOR: out = a ^ b;
            OP_ADD: begin
                out   = sum_s[WIDTH-1:0];
                carry = sum_s[WIDTH];
            end
            default: begin
                out   = {WIDTH{1'b0}};
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_4b_arbiter.sv
// Round-robin arbiter sharing one ALU datapath between two valid/ready requesters.
// Each accepted request runs IDLE -> EXEC -> RESP; results are held until consumed.
module alu_4b_arbiter
    import alu_4b_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_carry,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    state_t           state_r;
    logic             last_r;
    logic             id_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic             grant_valid_s;
    logic             grant_id_s;
    logic [WIDTH-1:0] core_out_s;
    logic             core_carry_s;

    // Grant decision: only in IDLE and out of reset; ties go to the requester not granted last.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if ((state_r == ST_IDLE) && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = ~last_r;
            end else if (req0_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b0;
            end else if (req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b1;
            end else begin
                grant_valid_s = 1'b0;
                grant_id_s    = 1'b0;
            end
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    assign req0_ready = grant_valid_s & ~grant_id_s;
    assign req1_ready = grant_valid_s &  grant_id_s;

    alu_4b_core #(.WIDTH(WIDTH)) u_core (
        .op    (op_r),
        .a     (a_r),
        .b     (b_r),
        .out   (core_out_s),
        .carry (core_carry_s)
    );

    // Sequencer: captures the granted request, registers the result, holds it until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            last_r    <= 1'b1;
            id_r      <= 1'b0;
            op_r      <= 2'b00;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            rsp_valid <= 1'b0;
            rsp_out   <= {WIDTH{1'b0}};
            rsp_carry <= 1'b0;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
            ops_done  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        op_r    <= grant_id_s ? req1_op : req0_op;
                        a_r     <= grant_id_s ? req1_a  : req0_a;
                        b_r     <= grant_id_s ? req1_b  : req0_b;
                        id_r    <= grant_id_s;
                        last_r  <= grant_id_s;
                        busy    <= 1'b1;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_out   <= core_out_s;
                    rsp_carry <= core_carry_s;
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                    state_r   <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                        if (ops_done != {CNT_W{1'b1}}) begin
                            ops_done <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_4b_arbiter.sv
// Directed, table-driven bench for alu_4b_arbiter; a second instance with CNT_W = 2
// shares the stimulus to exercise counter saturation.
module tb_alu_4b_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_ready;

    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry, busy;
    logic [3:0] rsp_out;
    logic [7:0] ops_done;

    logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_carry, s_busy;
    logic [3:0] s_rsp_out;
    logic [1:0] s_ops_done;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rid;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_out;
        logic       exp_carry;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    alu_4b_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_carry(rsp_carry), .busy(busy), .ops_done(ops_done)
    );

    alu_4b_arbiter #(.WIDTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_out(s_rsp_out),
        .rsp_carry(s_rsp_carry), .busy(s_busy), .ops_done(s_ops_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rid, input logic [1:0] op, input logic [3:0] a,
                                input logic [3:0] b, input logic [3:0] eo, input logic ec);
        vec_t v;
        v.rid = rid; v.op = op; v.a = a; v.b = b; v.exp_out = eo; v.exp_carry = ec;
        return v;
    endfunction

    task automatic drive(input logic rid, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        if (rid) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    initial begin
        int exp_sat;
        int exp_id;

        vecs[0] = mk(1'b0, 2'b00, 4'b1110, 4'b0010, 4'b0010, 1'b0);
        vecs[1] = mk(1'b1, 2'b11, 4'b1111, 4'b0001, 4'b0000, 1'b1);
        vecs[2] = mk(1'b0, 2'b01, 4'b1010, 4'b0101, 4'b1111, 1'b0);
        vecs[3] = mk(1'b1, 2'b10, 4'b1100, 4'b1010, 4'b0110, 1'b0);
        vecs[4] = mk(1'b0, 2'b11, 4'b0111, 4'b0101, 4'b1100, 1'b0);
        vecs[5] = mk(1'b1, 2'b00, 4'b1111, 4'b1111, 4'b1111, 1'b0);
        vecs[6] = mk(1'b0, 2'b10, 4'b1111, 4'b1111, 4'b0000, 1'b0);
        vecs[7] = mk(1'b1, 2'b11, 4'b1000, 4'b1001, 4'b0001, 1'b1);

        // Reset with both valids high
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'd0; req0_b = 4'd0;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 4'd0; req1_b = 4'd0;
        tick();
        tick();
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_ops_done", {24'd0, ops_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Table: one request at a time, response consumed immediately
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].rid, vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            chk("tbl_ready", {30'd0, req1_ready, req0_ready}, vecs[i].rid ? 32'd2 : 32'd1);
            chk("tbl_sat_ready", {30'd0, s_req1_ready, s_req0_ready}, vecs[i].rid ? 32'd2 : 32'd1);
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            chk("tbl_exec_busy", {31'd0, busy}, 32'd1);
            chk("tbl_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            tick();
            chk("tbl_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("tbl_rsp_out", {28'd0, rsp_out}, {28'd0, vecs[i].exp_out});
            chk("tbl_rsp_carry", {31'd0, rsp_carry}, {31'd0, vecs[i].exp_carry});
            chk("tbl_rsp_id", {31'd0, rsp_id}, {31'd0, vecs[i].rid});
            chk("tbl_sat_rsp", {25'd0, s_rsp_valid, s_rsp_id, s_rsp_carry, s_rsp_out},
                {25'd0, 1'b1, vecs[i].rid, vecs[i].exp_carry, vecs[i].exp_out});
            tick();
            exp_sat = (i + 1 > 3) ? 3 : i + 1;
            chk("tbl_idle_busy", {30'd0, s_busy, busy}, 32'd0);
            chk("tbl_ops_done", {24'd0, ops_done}, i + 1);
            chk("tbl_sat_ops_done", {30'd0, s_ops_done}, exp_sat);
        end

        // Round-robin with both valid continuously, after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 2'b11, 4'b0001, 4'b0001);
        drive(1'b1, 2'b11, 4'b0011, 4'b0011);
        for (int k = 0; k < 4; k++) begin
            exp_id = k % 2;
            #1;
            chk("rr_grant", {30'd0, req1_ready, req0_ready}, (exp_id == 1) ? 32'd2 : 32'd1);
            tick();
            chk("rr_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
            chk("rr_rsp_id", {31'd0, rsp_id}, exp_id);
            chk("rr_rsp_out", {28'd0, rsp_out}, (exp_id == 1) ? 32'd6 : 32'd2);
            chk("rr_resp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
        end
        chk("rr_ops_done", {24'd0, ops_done}, 32'd4);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Back-pressure: response held 5 cycles while requester 1 waits
        rsp_ready = 1'b0;
        drive(1'b0, 2'b10, 4'b0101, 4'b0011);
        tick();
        req0_valid = 1'b0;
        drive(1'b1, 2'b00, 4'b1011, 4'b0110);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_out", {28'd0, rsp_out}, 32'd6);
            chk("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
            chk("bp_ready_low", {30'd0, req1_ready, req0_ready}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_busy", {31'd0, busy}, 32'd0);
        chk("bp_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_release_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("bp_next_rsp_out", {28'd0, rsp_out}, 32'd2);
        chk("bp_next_rsp_id", {31'd0, rsp_id}, 32'd1);
        tick();
        chk("bp_ops_done", {24'd0, ops_done}, 32'd6);

        // Reset during EXEC drops the operation
        drive(1'b0, 2'b11, 4'b0100, 4'b0100);
        tick();
        req0_valid = 1'b0;
        chk("mid_exec_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_ops_done", {24'd0, ops_done}, 32'd0);
        chk("mid_sat_ops_done", {30'd0, s_ops_done}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("mid_no_rsp", {30'd0, busy, rsp_valid}, 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_4b_arbiter.md
# alu_4b_arbiter

Shares a single 4-bit ALU datapath (AND / OR / XOR / ADD) between two requesters using valid/ready handshakes and round-robin arbitration. Each request runs a fixed IDLE → EXEC → RESP sequence with registered operands and a registered result. The block sits between the requesting units and the 4-bit gate datapath, and is the only path by which requesters reach that datapath. A saturating counter of completed operations is exported for debug and test.

## Interface

Parameters:
- `WIDTH`, default 4: operand and result width.
- `CNT_W`, default 8: width of the completed-operation counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` input 1: requester 0 has a request.
- `req0_ready` output 1: requester 0 request accepted this cycle.
- `req0_op` input 2: opcode. 00 = AND, 01 = OR, 10 = XOR, 11 = ADD.
- `req0_a` input WIDTH: operand a.
- `req0_b` input WIDTH: operand b.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_id` output 1: index of the requester that issued the operation.
- `rsp_out` output WIDTH: result.
- `rsp_carry` output 1: carry-out for ADD; 0 for all logic ops.
- `busy` output 1: high when the FSM is not in IDLE.
- `ops_done` output CNT_W: count of completed responses, saturating.

## Operation

- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - Grant logic:
    - Exactly one `reqN_valid` high: grant that requester.
    - Both high: grant the requester that was not granted most recently.
    - The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - `reqN_ready` is high only for the granted requester, and only in IDLE. It is combinational from the valids and the pointer.
  - On handshake (`valid & ready`):
    - Capture op, a and b into operand registers.
    - Capture the granted index into `id_q`.
    - Update the last-grant pointer.
    - Go to EXEC.
- **EXEC:**
  - The datapath core evaluates the captured operands.
  - The result and carry are registered into `rsp_out` / `rsp_carry`; `rsp_id` is set from `id_q`.
  - Go to RESP unconditionally.
- **RESP:**
  - `rsp_valid` is high.
  - `rsp_out`, `rsp_carry` and `rsp_id` stay stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`:
    - Increment `ops_done`; it saturates at 2^CNT_W − 1 and never wraps.
    - Go to IDLE.
- Arithmetic: ADD is an unsigned WIDTH-bit sum. `rsp_out` is the sum modulo 2^WIDTH; `rsp_carry` is bit WIDTH of the full sum.
- Requester inputs are ignored outside IDLE. A requester holds `valid` and its payload until it sees `ready`.
- Reset values:
  - FSM state IDLE.
  - `rsp_valid` 0, `rsp_out` 0, `rsp_carry` 0, `rsp_id` 0.
  - `busy` 0, `ops_done` 0.
  - Last-grant pointer 1; `reqN_ready` 0 while `rst` is high.
- Reset mid-operation: the in-flight operation is dropped and no response is issued. `ops_done` is cleared.

## Timing

- Request accepted at edge N (end of cycle N):
  - EXEC occupies cycle N+1.
  - `rsp_valid` rises in cycle N+2.
  - Minimum latency is 2 cycles.
- Response accepted in cycle M:
  - The FSM is in IDLE in cycle M+1.
  - The next request can be accepted in cycle M+1.
- Minimum spacing between acceptances is 3 cycles when `rsp_ready` is tied high.
- No combinational path from `rsp_ready` to `reqN_ready`. No same-cycle accept of a new request during RESP.
- A `valid` that drops before `ready` is legal; no grant is recorded for it.

## Structure

- Shared package `alu_4b_pkg`:
  - Opcode constants `OP_AND`, `OP_OR`, `OP_XOR`, `OP_ADD`.
  - FSM state encoding `ST_IDLE`, `ST_EXEC`, `ST_RESP`.
- Sub-module `alu_4b_core`: purely combinational, with inputs op, a, b and outputs out, carry. It instantiates the existing 4-bit AND gate for the AND path.
- The arbiter holds the FSM, the last-grant pointer, operand/result registers and the counter.

## Test plan

- **Reset:** assert `rst` for 2 cycles with both valids high. Require `req0_ready = req1_ready = 0`, `rsp_valid = 0`, `ops_done = 0`. Release reset: `req0_ready = 1` in the first cycle.
- **Single AND:** requester 0, op 00, a = 1110, b = 0010. Require `rsp_valid` 2 cycles after accept, `rsp_out = 0010`, `rsp_carry = 0`, `rsp_id = 0`.
- **ADD with carry:** requester 1, a = 1111, b = 0001. Require `rsp_out = 0000`, `rsp_carry = 1`, `rsp_id = 1`.
- **Round-robin:** both valid continuously with `rsp_ready = 1`. Require grants alternating 0, 1, 0, 1 at 3-cycle spacing, and `ops_done = 4` after 4 responses.
- **Back-pressure:** hold `rsp_ready = 0` for 5 cycles in RESP. Require `rsp_out` / `rsp_id` stable, both `reqN_ready` low and `busy = 1`. Release: IDLE in the next cycle.
- **Mid-operation reset and saturation:**
  - Assert `rst` during EXEC: require no response and `ops_done = 0`.
  - With `CNT_W = 2`, complete 5 operations: require `ops_done = 3`.
